adc_scan_sched: RTL
===================

# adc_scan_sched

Channel scan scheduler for the adc082s021 SPI driver. It selects which ADC channel each SPI frame converts and starts frames on spi_master_ctrl. It accounts for the ADC's one-frame conversion pipeline, so each returned sample is attributed to the channel requested in the previous frame. Samples go to a per-channel result bank and a one-cycle sample stream for downstream logic.

## Interface
- NCHAN, 8: number of ADC channel slots in the mask and result bank.
- CHW, 3: channel index width; NCHAN ≤ 2**CHW.
- DWIDTH, 12: sample width; must match the driver's data port.

- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-low reset: 0 resets on the next posedge.
- start  in  1  pulse; begins a scan when in IDLE, ignored otherwise.
- stop  in  1  pulse; ends a continuous scan gracefully.
- continuous  in  1  sampled with start: 1 = repeat scans, 0 = single pass.
- chan_mask  in  NCHAN  enabled channels; latched at start and at each continuous wrap.
- adc_channel  out  CHW  channel index to the driver; held stable for the whole frame.
- spi_start  out  1  one-cycle pulse that starts a frame.
- spi_done  in  1  one-cycle pulse at frame end; adc_data is valid in that cycle.
- adc_data  in  DWIDTH  conversion result from the driver.
- smp_valid  out  1  one-cycle pulse for each attributed sample.
- smp_chan  out  CHW  channel of the sample.
- smp_data  out  DWIDTH  sample value.
- rd_chan  in  CHW  result bank read address.
- rd_data  out  DWIDTH  combinational read of the bank.
- rd_valid  out  1  bank entry written since the last start/reset.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse on the return to IDLE.

## Operation
- States:
  - IDLE: no frames issued.
  - PRIME: first frame; its returned data is discarded.
  - SCAN: each frame sends the next channel and returns the previous one.
  - DRAIN: final frame; fetches the data of the last channel sent.
- Channel order:
  - Ascending index, skipping disabled channels.
  - Wrap to the lowest enabled index at the end of the mask.
  - "Next" is found by a priority search above the current index.
- Pipeline tracking:
  - prev_chan holds the channel sent in the frame now completing.
  - On spi_done in SCAN or DRAIN: sample = {prev_chan, adc_data}, written to bank[prev_chan]; valid bit set.
- Transitions:
  - IDLE→PRIME: start with chan_mask ≠ 0.
  - start with chan_mask = 0: no frame; done pulses next cycle.
  - PRIME→SCAN: on spi_done.
  - SCAN, single pass: after the frame whose sent channel is the highest enabled, →DRAIN.
  - SCAN, continuous: wraps indefinitely; chan_mask is re-latched at wrap.
  - stop while in SCAN/PRIME: latch a stop request. The in-flight frame completes and its sample is written (PRIME data still discarded). Then →DRAIN.
  - DRAIN→IDLE: on spi_done, after writing the sample; done pulses.
- The channel sent during DRAIN is the first enabled channel. Its result is never read.
- With a single enabled channel, every frame sends the same channel.
- start clears all rd_valid bits. Bank data is retained.
- Reset, including mid-frame:
  - State returns to IDLE.
  - Cleared outputs: adc_channel=0, spi_start=0, smp_valid=0, smp_chan=0, smp_data=0, busy=0, done=0.
  - All valid bits and any latched stop request are cleared.
  - spi_done is ignored in IDLE.

## Timing
- start→spi_start: 1 cycle. adc_channel is valid in the same cycle as spi_start.
- spi_done→next spi_start: 1 cycle. adc_channel updates in that same cycle.
- spi_done→smp_valid and bank write: 1 cycle (registered). rd_valid is visible the following cycle.
- spi_done→done (DRAIN): 1 cycle, coincident with the final smp_valid.
- Simultaneous stop and start in IDLE: start wins and stop is ignored.
- Simultaneous stop and spi_done: the stop applies to the frame now starting. That frame is issued as DRAIN.
- Throughput: one sample per frame after PRIME. A single pass over N enabled channels takes N+1 frames.

## Configuration
- ADC_SCAN_THRESH_EN defined:
  - Adds input thresh [DWIDTH] and output alarm [NCHAN].
  - alarm[c] is set on a sample write to channel c when data > thresh (unsigned compare).
  - alarm[c] is cleared by a write with data ≤ thresh, by start, or by reset.
- Undefined: no thresh or alarm ports and no compare logic.

## Structure
- Package adc_scan_pkg holds:
  - The state enum (IDLE, PRIME, SCAN, DRAIN).
  - Default constants NCHAN, CHW, DWIDTH.
- Sub-module adc_scan_next_chan: combinational next-enabled-channel priority search (mask, current index → next index, wrap flag).

## Test plan
- Single pass, mask 8'b0000_0110:
  - Response: adc_channel sequence 1,2,1 across 3 frames. Samples (1,0xff0),(2,0x120) for frame data 0xAAA,0xff0,0x120.
  - Then done; rd_valid high only for channels 1 and 2.
- Mask 0 with start: no spi_start; done pulses 1 cycle later; busy stays 0.
- Continuous, mask 8'b1000_0001, stop after 5 frames:
  - Response: channels 0,7,0,7,0, then a DRAIN frame.
  - Final sample is attributed to channel 0.
  - Then done.
- Reset=0 mid-frame during SCAN:
  - All outputs return to reset values the next cycle; rd_valid is 0 for all channels.
  - A following spi_done produces no smp_valid.
- Stop and spi_done in the same cycle: the next frame is the DRAIN frame; exactly one further sample, then done.
- With ADC_SCAN_THRESH_EN and thresh=0x800:
  - Sample 0x900 on channel 3 → alarm[3]=1.
  - A later 0x100 on channel 3 → alarm[3]=0.

Source files
------------

// File: rtl/adc_scan_pkg.sv
// Shared types and default sizing for the adc082s021 channel scan scheduler.
package adc_scan_pkg;
    localparam int DEF_NCHAN  = 8;
    localparam int DEF_CHW    = 3;
    localparam int DEF_DWIDTH = 12;

    typedef enum logic [1:0] {IDLE, PRIME, SCAN, DRAIN} state_t;
endpackage

// File: rtl/adc_scan_next_chan.sv
// Next enabled channel strictly above cur; wraps to the lowest enabled index.
module adc_scan_next_chan import adc_scan_pkg::*; #(
    parameter int NCHAN = DEF_NCHAN,
    parameter int CHW   = DEF_CHW
) (
    input  logic [NCHAN-1:0] mask,
    input  logic [CHW-1:0]   cur,
    output logic [CHW-1:0]   nxt,
    output logic             wrap
);
    logic [CHW-1:0] above;
    logic [CHW-1:0] lowest;
    logic           hit;

    // Descending sweep so the last match kept is the lowest qualifying index.
    always_comb begin
        above  = '0;
        lowest = '0;
        hit    = 1'b0;
        for (int i = NCHAN - 1; i >= 0; i--) begin
            if (mask[i]) begin
                lowest = CHW'(i);
                if (i > int'(cur)) begin
                    above = CHW'(i);
                    hit   = 1'b1;
                end
            end
        end
        nxt  = hit ? above : lowest;
        wrap = ~hit;
    end
endmodule

// File: rtl/adc_scan_sched.sv
// ADC scan scheduler: drives frames, attributes pipelined samples, keeps a result bank.
// Optional threshold alarms are built when ADC_SCAN_THRESH_EN is defined.
module adc_scan_sched import adc_scan_pkg::*; #(
    parameter int NCHAN  = DEF_NCHAN,
    parameter int CHW    = DEF_CHW,
    parameter int DWIDTH = DEF_DWIDTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              continuous,
    input  logic [NCHAN-1:0]  chan_mask,
    output logic [CHW-1:0]    adc_channel,
    output logic              spi_start,
    input  logic              spi_done,
    input  logic [DWIDTH-1:0] adc_data,
    output logic              smp_valid,
    output logic [CHW-1:0]    smp_chan,
    output logic [DWIDTH-1:0] smp_data,
    input  logic [CHW-1:0]    rd_chan,
    output logic [DWIDTH-1:0] rd_data,
    output logic              rd_valid,
    output logic              busy,
    output logic              done
`ifdef ADC_SCAN_THRESH_EN
    ,
    input  logic [DWIDTH-1:0] thresh,
    output logic [NCHAN-1:0]  alarm
`endif
);
    localparam logic [CHW-1:0] LAST = CHW'(NCHAN - 1);

    state_t            state, state_n;
    logic [NCHAN-1:0]  mask_q, mask_n;
    logic              cont_q, cont_n;
    logic              stop_q, stop_n;
    logic [CHW-1:0]    prev_chan, prev_n;
    logic [CHW-1:0]    chan_n;
    logic              spi_start_n, smp_valid_n, done_n;
    logic [CHW-1:0]    smp_chan_n;
    logic [DWIDTH-1:0] smp_data_n;
    logic              wr_en, clr_vld;

    logic [NCHAN-1:0]  bank_vld;
    logic [DWIDTH-1:0] bank [NCHAN];

    logic [CHW-1:0]    step_nxt, live_first, q_first;
    logic              step_wrap, live_wrap_unused, q_wrap_unused;

    adc_scan_next_chan #(.NCHAN(NCHAN), .CHW(CHW)) u_step (
        .mask(mask_q), .cur(adc_channel), .nxt(step_nxt), .wrap(step_wrap)
    );
    adc_scan_next_chan #(.NCHAN(NCHAN), .CHW(CHW)) u_live_first (
        .mask(chan_mask), .cur(LAST), .nxt(live_first), .wrap(live_wrap_unused)
    );
    adc_scan_next_chan #(.NCHAN(NCHAN), .CHW(CHW)) u_q_first (
        .mask(mask_q), .cur(LAST), .nxt(q_first), .wrap(q_wrap_unused)
    );

    always_comb begin
        state_n     = state;
        chan_n      = adc_channel;
        prev_n      = prev_chan;
        mask_n      = mask_q;
        cont_n      = cont_q;
        stop_n      = stop_q;
        spi_start_n = 1'b0;
        smp_valid_n = 1'b0;
        smp_chan_n  = smp_chan;
        smp_data_n  = smp_data;
        done_n      = 1'b0;
        wr_en       = 1'b0;
        clr_vld     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    clr_vld = 1'b1;
                    stop_n  = 1'b0;
                    if (|chan_mask) begin
                        state_n     = PRIME;
                        mask_n      = chan_mask;
                        cont_n      = continuous;
                        chan_n      = live_first;
                        spi_start_n = 1'b1;
                    end else begin
                        done_n = 1'b1;
                    end
                end
            end
            PRIME, SCAN: begin
                stop_n = stop_q | stop;
                if (spi_done) begin
                    // PRIME data belongs to no requested channel and is dropped.
                    wr_en       = (state == SCAN);
                    prev_n      = adc_channel;
                    spi_start_n = 1'b1;
                    state_n     = SCAN;
                    if (stop_q || stop) begin
                        state_n = DRAIN;
                        chan_n  = q_first;
                    end else if (!step_wrap) begin
                        chan_n = step_nxt;
                    end else if (cont_q && (|chan_mask)) begin
                        mask_n = chan_mask;
                        chan_n = live_first;
                    end else begin
                        state_n = DRAIN;
                        chan_n  = step_nxt;
                    end
                end
            end
            DRAIN: begin
                if (spi_done) begin
                    wr_en   = 1'b1;
                    state_n = IDLE;
                    done_n  = 1'b1;
                    stop_n  = 1'b0;
                end
            end
            default: state_n = IDLE;
        endcase
        if (wr_en) begin
            smp_valid_n = 1'b1;
            smp_chan_n  = prev_chan;
            smp_data_n  = adc_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            mask_q      <= '0;
            cont_q      <= 1'b0;
            stop_q      <= 1'b0;
            prev_chan   <= '0;
            adc_channel <= '0;
            spi_start   <= 1'b0;
            smp_valid   <= 1'b0;
            smp_chan    <= '0;
            smp_data    <= '0;
            done        <= 1'b0;
            bank_vld    <= '0;
        end else begin
            state       <= state_n;
            mask_q      <= mask_n;
            cont_q      <= cont_n;
            stop_q      <= stop_n;
            prev_chan   <= prev_n;
            adc_channel <= chan_n;
            spi_start   <= spi_start_n;
            smp_valid   <= smp_valid_n;
            smp_chan    <= smp_chan_n;
            smp_data    <= smp_data_n;
            done        <= done_n;
            if (clr_vld)
                bank_vld <= '0;
            else if (wr_en)
                bank_vld[prev_chan] <= 1'b1;
        end
    end

    // Sample storage survives start and reset; only the valid bits are cleared.
    always_ff @(posedge clk) begin
        if (reset && wr_en)
            bank[prev_chan] <= adc_data;
    end

`ifdef ADC_SCAN_THRESH_EN
    always_ff @(posedge clk) begin
        if (!reset)
            alarm <= '0;
        else if (clr_vld)
            alarm <= '0;
        else if (wr_en)
            alarm[prev_chan] <= (adc_data > thresh);
    end
`endif

    assign rd_data  = bank[rd_chan];
    assign rd_valid = bank_vld[rd_chan];
    assign busy     = (state != IDLE);
endmodule
